// File: rtl/tlul_slave_mem_responder.sv
// rtl/tlul_slave_mem_responder.sv - single-outstanding TL-UL responder over a word-addressed register memory
module tlul_slave_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 1,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int MEM_WORDS    = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int RESP_LATENCY = 2
) (
  input  logic                    clk_24,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);
  localparam int LANE_BITS = $clog2(MASK_WIDTH);
  localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W     = $clog2(RESP_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * MASK_WIDTH);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL    = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET         = OPCODE_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_ready_d, d_valid_d;
  logic             accept, req_err, is_get, is_put, wr_en;
  logic             size_err, align_err, range_err, op_err, mask_err;
  logic [ADDR_WIDTH:0]    rel;
  logic [IDX_W-1:0]       idx;
  logic [MASK_WIDTH-1:0]  win;
  int                     off_i, nbytes;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Addresses below BASE_ADDR wrap to a huge rel value and fail the range check too.
  assign rel    = {1'b0, a_address} - {1'b0, BASE_ADDR};
  assign idx    = rel[LANE_BITS +: IDX_W];
  assign accept = a_valid && a_ready && (state_q == IDLE);
  assign is_get = (a_opcode == OP_GET);
  assign is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
  assign wr_en  = accept && is_put && !req_err;

  always_comb begin
    off_i  = int'(a_address[LANE_BITS-1:0]);
    nbytes = 1 << a_size;
    win    = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (i >= off_i && i < off_i + nbytes) win[i] = 1'b1;
    end
    size_err  = a_size > SIZE_WIDTH'(LANE_BITS);
    align_err = !size_err && ((off_i & (nbytes - 1)) != 0);
    range_err = rel >= MEM_BYTES;
    op_err    = !(is_put || is_get);
    mask_err  = ((a_opcode == OP_PUT_FULL) && (a_mask != win)) ||
                ((a_opcode == OP_PUT_PARTIAL) && ((a_mask & ~win) != '0));
    req_err   = size_err || align_err || range_err || op_err || mask_err;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (RESP_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(RESP_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        // d_valid trails entry into RESP by one edge so latency lands on N+RESP_LATENCY.
        if (d_valid && d_ready) state_d = IDLE;
        else                    d_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    a_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_24) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_ready  <= 1'b0;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_ready <= a_ready_d;
      d_valid <= d_valid_d;
      if (accept) begin
        d_opcode <= is_get ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
        d_size   <= a_size;
        d_source <= a_source;
        d_error  <= req_err;
        d_data   <= (is_get && !req_err) ? mem[idx] : '0;
      end
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk_24) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  assign d_param = '0;
  assign d_sink  = '0;

  logic unused_bits;
  assign unused_bits = ^{a_param, rel};
endmodule

// File: tb/tb_tlul_slave_mem_responder.sv
// tb/tb_tlul_slave_mem_responder.sv - directed self-checking bench for tlul_slave_mem_responder
module tb_tlul_slave_mem_responder;
  logic        clk_24 = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic        a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic        d_source, d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int checks = 0;
  int errors = 0;

  tlul_slave_mem_responder dut (
    .clk_24(clk_24), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error)
  );

  always #5 clk_24 = ~clk_24;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [2:0] size, input logic src);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_size = size; a_source = src; a_param = 3'd0;
  endtask

  // Returns at the negedge after the accept edge with a_valid dropped.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!a_ready && n < 20) begin
      @(negedge clk_24);
      n++;
    end
    chk({tag, "_a_ready"}, a_ready, 1);
    @(posedge clk_24);
    @(negedge clk_24);
    a_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, output int lat);
    lat = 0;
    while (!d_valid && lat < 20) begin
      @(posedge clk_24);
      lat++;
      @(negedge clk_24);
    end
    chk({tag, "_d_valid"}, d_valid, 1);
  endtask

  task automatic txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data, input logic [2:0] size,
                     input logic src, input logic [2:0] e_op, input logic [31:0] e_data,
                     input logic e_err, input logic chk_data);
    int lat;
    @(negedge clk_24);
    drive_a(op, addr, mask, data, size, src);
    wait_accept(tag);
    wait_resp(tag, lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_opcode"}, d_opcode, e_op);
    chk({tag, "_error"}, d_error, e_err);
    chk({tag, "_source"}, d_source, src);
    chk({tag, "_size"}, d_size, size);
    if (chk_data) chk({tag, "_data"}, d_data, e_data);
    @(posedge clk_24);
  endtask

  initial begin
    logic [31:0] held_data;
    logic [2:0]  held_op;
    int lat;
    int seen;

    reset = 1'b0; d_ready = 1'b1; a_valid = 1'b0;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0;
    repeat (3) @(posedge clk_24);
    @(negedge clk_24);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_d_error", d_error, 0);
    chk("rst_d_opcode", d_opcode, 0);
    reset = 1'b1;
    @(negedge clk_24);
    chk("rel_a_ready", a_ready, 1);

    txn("put_full",  3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 3'd2, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
    txn("get_10a",   3'd4, 32'h10, 4'hF, 32'h0,        3'd2, 1'b0, 3'd1, 32'hDEADBEEF, 1'b0, 1'b1);
    txn("put_part",  3'd1, 32'h10, 4'h3, 32'h0000CAFE, 3'd2, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    txn("get_10b",   3'd4, 32'h10, 4'hF, 32'h0,        3'd2, 1'b1, 3'd1, 32'hDEADCAFE, 1'b0, 1'b1);
    txn("put_mask0", 3'd1, 32'h10, 4'h0, 32'h11111111, 3'd2, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    txn("get_10c",   3'd4, 32'h10, 4'hF, 32'h0,        3'd2, 1'b0, 3'd1, 32'hDEADCAFE, 1'b0, 1'b1);
    txn("get_oob",   3'd4, 32'h400, 4'hF, 32'h0,       3'd2, 1'b1, 3'd1, 32'h0, 1'b1, 1'b1);
    txn("get_misal", 3'd4, 32'h12, 4'hF, 32'h0,        3'd2, 1'b0, 3'd1, 32'h0, 1'b1, 1'b1);
    txn("put_badmsk",3'd0, 32'h12, 4'h3, 32'h99999999, 3'd1, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    txn("get_10d",   3'd4, 32'h10, 4'hF, 32'h0,        3'd2, 1'b0, 3'd1, 32'hDEADCAFE, 1'b0, 1'b1);
    txn("put_20",    3'd0, 32'h20, 4'hF, 32'hA5A5A5A5, 3'd2, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    txn("bad_op",    3'd3, 32'h20, 4'hF, 32'h12345678, 3'd2, 1'b1, 3'd0, 32'h0, 1'b1, 1'b0);
    txn("get_20",    3'd4, 32'h20, 4'hF, 32'h0,        3'd2, 1'b0, 3'd1, 32'hA5A5A5A5, 1'b0, 1'b1);

    // Backpressure with a queued Get waiting on the A channel.
    @(negedge clk_24);
    d_ready = 1'b0;
    drive_a(3'd4, 32'h10, 4'hF, 32'h0, 3'd2, 1'b1);
    wait_accept("bp");
    drive_a(3'd4, 32'h20, 4'hF, 32'h0, 3'd2, 1'b0);
    wait_resp("bp", lat);
    held_data = d_data;
    held_op   = d_opcode;
    chk("bp_data", d_data, 32'hDEADCAFE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_24);
      @(negedge clk_24);
      chk("bp_hold_valid", d_valid, 1);
      chk("bp_hold_data", d_data, held_data);
      chk("bp_hold_op", d_opcode, held_op);
      chk("bp_hold_src", d_source, 1);
      chk("bp_a_ready", a_ready, 0);
    end
    d_ready = 1'b1;
    @(posedge clk_24);
    @(negedge clk_24);
    chk("bp_drop_valid", d_valid, 0);
    chk("bp_ready_back", a_ready, 1);
    @(posedge clk_24);
    @(negedge clk_24);
    a_valid = 1'b0;
    chk("q_accepted", a_ready, 0);
    wait_resp("q", lat);
    chk("q_lat", lat, 2);
    chk("q_data", d_data, 32'hA5A5A5A5);
    chk("q_source", d_source, 0);
    @(posedge clk_24);

    // Reset during WAIT aborts the response.
    @(negedge clk_24);
    drive_a(3'd4, 32'h10, 4'hF, 32'h0, 3'd2, 1'b0);
    wait_accept("rw");
    reset = 1'b0;
    @(posedge clk_24);
    @(negedge clk_24);
    chk("rw_d_valid", d_valid, 0);
    chk("rw_a_ready", a_ready, 0);
    @(posedge clk_24);
    @(negedge clk_24);
    chk("rw_d_valid2", d_valid, 0);
    reset = 1'b1;
    @(posedge clk_24);
    @(negedge clk_24);
    chk("rw_rel_ready", a_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (d_valid) seen++;
      @(posedge clk_24);
      @(negedge clk_24);
    end
    chk("rw_no_resp", seen, 0);

    txn("get_post", 3'd4, 32'h10, 4'hF, 32'h0, 3'd2, 1'b1, 3'd1, 32'hDEADCAFE, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
